// File: rtl/issue_trace_buffer.sv
// issue_trace_buffer: captures per-cycle retire information from the issue
// lanes into a circular trace buffer, readable through a show-ahead
// valid/ready port.
// Optional build macro TRACE_TIMESTAMP_EN adds a free-running cycle counter
// whose value is stored in the top TS_W bits of every entry.
module issue_trace_buffer #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_BITS = TS_W,
`else
  // Without the counter the timestamp width contributes nothing to an entry.
  localparam int TS_BITS = (TS_W > 0) ? 0 : 0,
`endif
  localparam int ENTRY_W = LANES * (33 + DATA_W) + TS_BITS,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      mode_wrap,
  input  logic                      trig_en,
  input  logic [31:0]               trig_ins,
  input  logic [LANES-1:0]          lane_valid,
  input  logic [LANES*32-1:0]       lane_ins,
  input  logic [LANES*DATA_W-1:0]   lane_result,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [ENTRY_W-1:0]        rd_data,
  output logic [AW:0]               count,
  output logic [1:0]                state,
  output logic                      overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0]         state_reg, state_next;
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic               overflow_reg;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] entry_in;

  logic [LANES-1:0]   lane_match;
  logic               trig_hit;
  logic               any_valid;
  logic               full;
  logic               arm_ok;
  logic               pop_eff;
  logic               push_req;
  logic               discard;
  logic               drop;
  logic               do_push;
  logic               in_armed;
  logic               in_capture;

  // Per-lane trigger comparators: a lane matches only when it actually retires.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_match
      assign lane_match[gi] = lane_valid[gi] && (lane_ins[gi*32 +: 32] == trig_ins);
    end
  endgenerate

  assign trig_hit  = |lane_match;
  assign any_valid = |lane_valid;
  assign full      = (count_reg == CNT_FULL);

  // arm is only honoured outside CAPTURE; when honoured it flushes the buffer,
  // so any pop or push in that same cycle is discarded.
  assign arm_ok   = arm && !in_capture;
  assign pop_eff  = rd_valid && rd_ready && !arm_ok;
  assign push_req = !arm_ok && any_valid && (in_capture || (in_armed && trig_hit));

  // A push into a full buffer either evicts the head (wrap mode) or is lost
  // (stop mode); a simultaneous pop always makes room instead.
  assign discard = push_req && full && !pop_eff && mode_wrap;
  assign drop    = push_req && full && !pop_eff && !mode_wrap;
  assign do_push = push_req && !drop;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) ts_reg <= '0;
    else     ts_reg <= ts_reg + TS_W'(1);
  end

  assign entry_in = {ts_reg, lane_result, lane_ins, lane_valid};
`else
  assign entry_in = {lane_result, lane_ins, lane_valid};
`endif

  // Trace storage; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= entry_in;
  end

  // Head of the queue read straight out of storage so a newly written entry
  // is visible the cycle after its write; forced to zero when empty.
  assign rd_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || arm_ok) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_eff || discard)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (do_push && !(pop_eff || discard))
        count_reg <= count_reg + CNT_ONE;
      else if (!do_push && pop_eff)
        count_reg <= count_reg - CNT_ONE;
      if (discard)
        overflow_reg <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic; stop beats arm in CAPTURE because arm is ignored there.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (arm) state_next = trig_en ? ST_ARMED : ST_CAPTURE;
      end
      ST_ARMED: begin
        if (arm)           state_next = trig_en ? ST_ARMED : ST_CAPTURE;
        else if (trig_hit) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop || drop) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM-derived outputs and decodes.
  always_comb begin
    in_armed   = (state_reg == ST_ARMED);
    in_capture = (state_reg == ST_CAPTURE);
    state      = state_reg;
    rd_valid   = (count_reg != '0);
    count      = count_reg;
    overflow   = overflow_reg;
  end

endmodule

// File: tb/tb_issue_trace_buffer.sv
// tb_issue_trace_buffer: directed scenarios plus randomized traffic for
// issue_trace_buffer, checked against a queue-based reference model.
module tb_issue_trace_buffer;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TSB = TS_W;
`else
  localparam int TSB = 0;
`endif
  localparam int ENTRY_W = LANES * (33 + DATA_W) + TSB;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int RES0    = LANES * 33;   // bit offset of lane 0 result
  localparam int INS0    = LANES;        // bit offset of lane 0 instruction

  logic                    clk = 1'b0;
  logic                    rst, arm, stop, mode_wrap, trig_en, rd_ready;
  logic [31:0]             trig_ins;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*32-1:0]     lane_ins;
  logic [LANES*DATA_W-1:0] lane_result;
  logic                    rd_valid;
  logic [ENTRY_W-1:0]      rd_data;
  logic [CW-1:0]           count;
  logic [1:0]              state;
  logic                    overflow;

  issue_trace_buffer #(
    .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode_wrap(mode_wrap),
    .trig_en(trig_en), .trig_ins(trig_ins), .lane_valid(lane_valid),
    .lane_ins(lane_ins), .lane_result(lane_result), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .count(count), .state(state),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [ENTRY_W-1:0] mq[$];
  int                 m_state;
  bit                 m_ovf;
  logic [TS_W-1:0]    m_ts;
  int                 errors = 0;
  int                 checks = 0;

  function automatic logic [ENTRY_W-1:0] make_entry();
`ifdef TRACE_TIMESTAMP_EN
    return {m_ts, lane_result, lane_ins, lane_valid};
`else
    return {lane_result, lane_ins, lane_valid};
`endif
  endfunction

  // One clock edge of the specified behaviour, using the inputs held this cycle.
  function automatic void model_cycle();
    bit hit, push, dropped;
    logic [ENTRY_W-1:0] e;
    if (rst) begin
      mq.delete(); m_state = 0; m_ovf = 0; m_ts = '0;
      return;
    end
    hit = 0;
    for (int l = 0; l < LANES; l++)
      if (lane_valid[l] && lane_ins[l*32 +: 32] == trig_ins) hit = 1;
    e = make_entry();
    if (arm && m_state != 2) begin
      mq.delete(); m_ovf = 0;
      m_state = trig_en ? 1 : 2;
    end else begin
      push = (lane_valid != '0) && (m_state == 2 || (m_state == 1 && hit));
      if (rd_ready && mq.size() != 0) begin
        $display("pop  t=%0t data=%h", $time, mq[0]);
        void'(mq.pop_front());
      end
      dropped = 0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else if (mode_wrap) begin void'(mq.pop_front()); mq.push_back(e); m_ovf = 1; end
        else dropped = 1;
      end
      if (m_state == 1 && hit) m_state = 2;
      else if (m_state == 2 && (stop || dropped)) m_state = 3;
    end
    m_ts = m_ts + 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_cycle();
    #1;
  endtask

  task automatic clear_inputs();
    arm = 0; stop = 0; rd_ready = 0; lane_valid = '0;
    lane_ins = '0; lane_result = '0;
  endtask

  task automatic drive_lanes(input logic [LANES-1:0] v, input logic [31:0] id);
    lane_valid = v;
    for (int l = 0; l < LANES; l++) begin
      lane_ins[l*32 +: 32] = $urandom;
      if (lane_ins[l*32 +: 32] == trig_ins) lane_ins[l*32] = ~lane_ins[l*32];
      lane_result[l*DATA_W +: DATA_W] = (l == 0) ? DATA_W'(id) : DATA_W'($urandom);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; mode_wrap = 0; trig_en = 0; trig_ins = 32'h0;
    clear_inputs();
    tick(); tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 0;
    tick();
  endtask

  task automatic test_direct_capture();
    trig_en = 0; mode_wrap = 0; trig_ins = 32'h00500093;
    arm = 1; tick(); arm = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL direct_state_after_arm: got %0d expected 2", state); end
    for (int i = 1; i <= 3; i++) begin drive_lanes(2'b11, i); tick(); end
    lane_valid = '0; stop = 1; tick(); stop = 0;
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL direct_count: got %0d expected 3", count); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL direct_state: got %0d expected 3", state); end
    for (int i = 1; i <= 3; i++) begin
      rd_ready = 1;
      checks++; if (rd_data[LANES-1:0] !== 2'b11) begin errors++; $display("FAIL direct_mask%0d: got %b expected 11", i, rd_data[LANES-1:0]); end
      checks++; if (rd_data[RES0 +: DATA_W] !== DATA_W'(i)) begin errors++; $display("FAIL direct_order%0d: got %0d expected %0d", i, rd_data[RES0 +: DATA_W], i); end
      checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL direct_entry%0d: got %h expected %h", i, rd_data, mq[0]); end
      tick();
    end
    rd_ready = 0;
    checks++; if (rd_data !== '0 || rd_valid !== 1'b0) begin errors++; $display("FAIL direct_empty: got valid=%b data=%h expected 0/0", rd_valid, rd_data); end
  endtask

  task automatic test_trigger();
    trig_en = 1; trig_ins = 32'h00500093;
    arm = 1; tick(); arm = 0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL trig_armed: got %0d expected 1", state); end
    for (int c = 1; c <= 4; c++) begin drive_lanes(2'($urandom_range(1, 3)), c); tick(); end
    checks++; if (state !== 2'd1 || count !== '0) begin errors++; $display("FAIL trig_wait: got state=%0d count=%0d expected 1/0", state, count); end
    drive_lanes(2'b11, 5); lane_ins[63:32] = trig_ins; tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_capture: got %0d expected 2", state); end
    lane_valid = '0; stop = 1; tick(); stop = 0;
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL trig_count: got %0d expected 1", count); end
    checks++; if (rd_data[INS0 + 32 +: 32] !== 32'h00500093) begin errors++; $display("FAIL trig_ins: got %h expected 00500093", rd_data[INS0 + 32 +: 32]); end
    checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL trig_entry: got %h expected %h", rd_data, mq[0]); end
    rd_ready = 1; tick(); rd_ready = 0;
  endtask

  task automatic test_stop_full();
    trig_en = 0; mode_wrap = 0;
    arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 20; i++) begin drive_lanes(2'b11, i); tick(); end
    lane_valid = '0;
    checks++; if (count !== CW'(16)) begin errors++; $display("FAIL stopfull_count: got %0d expected 16", count); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL stopfull_state: got %0d expected 3", state); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stopfull_overflow: got %b expected 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      rd_ready = 1;
      checks++; if (rd_data[RES0 +: DATA_W] !== DATA_W'(i)) begin errors++; $display("FAIL stopfull_id%0d: got %0d expected %0d", i, rd_data[RES0 +: DATA_W], i); end
      tick();
    end
    rd_ready = 0;
    checks++; if (count !== '0 || rd_valid !== 1'b0) begin errors++; $display("FAIL stopfull_drained: got count=%0d valid=%b expected 0/0", count, rd_valid); end
  endtask

  task automatic test_wrap();
    trig_en = 0; mode_wrap = 1;
    arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 20; i++) begin drive_lanes(2'b11, i); tick(); end
    lane_valid = '0;
    checks++; if (count !== CW'(16)) begin errors++; $display("FAIL wrap_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_overflow: got %b expected 1", overflow); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL wrap_state: got %0d expected 2", state); end
    stop = 1; tick(); stop = 0;
    for (int i = 5; i <= 20; i++) begin
      rd_ready = 1;
      checks++; if (rd_data[RES0 +: DATA_W] !== DATA_W'(i)) begin errors++; $display("FAIL wrap_id%0d: got %0d expected %0d", i, rd_data[RES0 +: DATA_W], i); end
      tick();
    end
    rd_ready = 0; mode_wrap = 0;
  endtask

  task automatic test_back_to_back();
    trig_en = 0; mode_wrap = 0;
    arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 16; i++) begin drive_lanes(2'b01, i); tick(); end
    checks++; if (count !== CW'(16) || state !== 2'd2) begin errors++; $display("FAIL b2b_full: got count=%0d state=%0d expected 16/2", count, state); end
    for (int i = 0; i < 3; i++) begin
      drive_lanes(2'b10, 100 + i); rd_ready = 1; tick();
      checks++; if (count !== CW'(16) || overflow !== 1'b0) begin errors++; $display("FAIL b2b_pushpop%0d: got count=%0d ovf=%b expected 16/0", i, count, overflow); end
      checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL b2b_head%0d: got %h expected %h", i, rd_data, mq[0]); end
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL b2b_state: got %0d expected 2", state); end
    // Arm is ignored while capturing.
    drive_lanes(2'b11, 7); rd_ready = 0; arm = 1; mode_wrap = 1; tick(); arm = 0; mode_wrap = 0;
    checks++; if (state !== 2'd2 || count !== CW'(16)) begin errors++; $display("FAIL b2b_arm_ignored: got state=%0d count=%0d expected 2/16", state, count); end
    // Reset mid-capture beats push, pop and stop.
    rst = 1; stop = 1; rd_ready = 1; drive_lanes(2'b11, 9); tick();
    rst = 0; stop = 0; rd_ready = 0; lane_valid = '0;
    checks++; if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_reset: got state=%0d count=%0d valid=%b expected 0/0/0", state, count, rd_valid); end
    checks++; if (overflow !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL b2b_reset_data: got ovf=%b data=%h expected 0/0", overflow, rd_data); end
  endtask

  task automatic test_arm_flush();
    trig_en = 0; arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 4; i++) begin drive_lanes(2'b11, i); tick(); end
    lane_valid = '0; stop = 1; arm = 1; tick(); stop = 0; arm = 0;
    checks++; if (state !== 2'd3 || count !== CW'(4)) begin errors++; $display("FAIL flush_stop_wins: got state=%0d count=%0d expected 3/4", state, count); end
    trig_en = 1; arm = 1; rd_ready = 1; tick(); arm = 0; rd_ready = 0;
    checks++; if (state !== 2'd1 || count !== '0) begin errors++; $display("FAIL flush_arm: got state=%0d count=%0d expected 1/0", state, count); end
  endtask

  task automatic test_random();
    trig_ins = 32'hDEAD0013;
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      arm       = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      trig_en   = $urandom_range(0, 1);
      rd_ready  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) mode_wrap = ~mode_wrap;
      lane_valid = LANES'($urandom);
      for (int l = 0; l < LANES; l++) begin
        lane_ins[l*32 +: 32] = ($urandom_range(0, 7) == 0) ? trig_ins : $urandom;
        lane_result[l*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      tick();
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state c=%0d: got %0d expected %0d", c, state, m_state); end
      checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow c=%0d: got %b expected %b", c, overflow, m_ovf); end
      checks++; if (rd_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_rd_valid c=%0d: got %b expected %b", c, rd_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL rnd_rd_data c=%0d: got %h expected %h", c, rd_data, mq[0]); end
      end else begin
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL rnd_rd_data c=%0d: got %h expected 0", c, rd_data); end
      end
    end
    clear_inputs(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_direct_capture();
    test_trigger();
    test_stop_full();
    test_wrap();
    test_back_to_back();
    test_arm_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
